// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch display path: BCD width, segment patterns
// (active-high, {g,f,e,d,c,b,a}) and the blink phase type.
package stopwatch_pkg;

  localparam int unsigned BCD_W = 4;
  localparam int unsigned SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h40;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  typedef enum logic {
    PHASE_OFF = 1'b0,
    PHASE_ON  = 1'b1
  } blink_phase_e;

endpackage

// File: rtl/stopwatch_seg_scan_if.sv
// Display-driver bus: BCD digit/dp requests in, multiplexed anode/segment drive out.
interface stopwatch_seg_scan_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  import stopwatch_pkg::*;

  logic [BCD_W*NUM_DIGITS-1:0] digits_i;
  logic [NUM_DIGITS-1:0]       dp_i;
  logic                        blank_lz_i;
  logic                        blink_i;
  logic [NUM_DIGITS-1:0]       an_o;
  logic [SEG_W-1:0]            seg_o;
  logic                        dp_o;
  logic                        frame_o;

  modport master (
    output digits_i, dp_i, blank_lz_i, blink_i,
    input  an_o, seg_o, dp_o, frame_o
  );

  modport slave (
    input  digits_i, dp_i, blank_lz_i, blink_i,
    output an_o, seg_o, dp_o, frame_o
  );

endinterface

// File: rtl/bcd_to_seg.sv
// BCD code to active-high seven-segment pattern; codes A-F show a dash.
module bcd_to_seg
  import stopwatch_pkg::*;
(
  input  logic [BCD_W-1:0] code,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_DASH;
    case (code)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/stopwatch_seg_scan.sv
// Time-multiplexed seven-segment scanner with per-frame digit snapshot,
// leading-zero blanking, decimal points and paused-display blink.
module stopwatch_seg_scan
  import stopwatch_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned GUARD          = 2,
  parameter int unsigned BLINK_FRAMES   = 32,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned AN_ACTIVE_LOW  = 1
) (
  input  logic                 CLK,
  input  logic                 CLR,
  stopwatch_seg_scan_if.slave  bus
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // XOR masks that convert active-high internal values to the pin polarity
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic [SEG_W-1:0]      SEG_OFF = (SEG_ACTIVE_LOW != 0) ? '1 : '0;
  localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);

  logic [PW-1:0]                    presc_q;
  logic [IW-1:0]                    idx_q;
  logic [NUM_DIGITS-1:0][BCD_W-1:0] snap_digit_q;
  logic [NUM_DIGITS-1:0]            snap_dp_q;
  logic                             started_q;
  logic [BW-1:0]                    blink_cnt_q;
  blink_phase_e                     phase_q;

  logic [NUM_DIGITS-1:0]            an_q;
  logic [SEG_W-1:0]                 seg_q;
  logic                             dp_q;
  logic                             frame_q;

  logic                             slot_tick_c;
  logic                             frame_tick_c;
  logic [NUM_DIGITS-1:0]            blank_c;
  logic [BCD_W-1:0]                 cur_digit_c;
  logic [SEG_W-1:0]                 seg_pat_c;
  logic                             show_c;
  logic [NUM_DIGITS-1:0]            an_next_c;

  assign slot_tick_c  = (presc_q == PW'(SCAN_DIV - 1));
  assign frame_tick_c = slot_tick_c && (idx_q == IW'(NUM_DIGITS - 1));

  // Slot prescaler and digit index; the first wrap to digit 0 starts the display
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      presc_q   <= '0;
      idx_q     <= IW'(NUM_DIGITS - 1);
      started_q <= 1'b0;
    end else begin
      presc_q <= slot_tick_c ? '0 : presc_q + PW'(1);
      if (slot_tick_c) begin
        idx_q <= frame_tick_c ? '0 : idx_q + IW'(1);
      end
      if (frame_tick_c) begin
        started_q <= 1'b1;
      end
    end
  end

  // Frame snapshot keeps a mid-frame rollover from tearing the display
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      snap_digit_q <= '0;
      snap_dp_q    <= '0;
    end else if (frame_tick_c) begin
      snap_digit_q <= bus.digits_i;
      snap_dp_q    <= bus.dp_i;
    end
  end

  // Blink phase toggles every BLINK_FRAMES frames while blink_i is held high
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      blink_cnt_q <= '0;
      phase_q     <= PHASE_ON;
    end else if (!bus.blink_i) begin
      blink_cnt_q <= '0;
      phase_q     <= PHASE_ON;
    end else if (frame_tick_c) begin
      if (blink_cnt_q == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_q <= '0;
        phase_q     <= (phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
      end
    end
  end

  // Digit k is blanked when it and every more-significant digit are zero
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    blank_c  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (snap_digit_q[k] == '0);
      if (k != 0) begin
        blank_c[k] = bus.blank_lz_i && zero_run;
      end
    end
  end

  assign cur_digit_c = snap_digit_q[idx_q];

  bcd_to_seg u_bcd_to_seg (
    .code  (cur_digit_c),
    .seg_c (seg_pat_c)
  );

  // Live blink_i overrides the phase so a resumed display appears at once
  assign show_c = started_q
               && (presc_q >= PW'(GUARD))
               && !blank_c[idx_q]
               && ((phase_q == PHASE_ON) || !bus.blink_i);

  assign an_next_c = show_c ? (NUM_DIGITS'(1) << idx_q) : '0;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      an_q    <= AN_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= DP_OFF;
      frame_q <= 1'b0;
    end else begin
      an_q    <= an_next_c ^ AN_OFF;
      seg_q   <= seg_pat_c ^ SEG_OFF;
      dp_q    <= (show_c && snap_dp_q[idx_q]) ^ DP_OFF;
      frame_q <= frame_tick_c;
    end
  end

  assign bus.an_o    = an_q;
  assign bus.seg_o   = seg_q;
  assign bus.dp_o    = dp_q;
  assign bus.frame_o = frame_q;

endmodule

// File: tb/tb_stopwatch_seg_scan.sv
// Randomized bench for stopwatch_seg_scan against a cycle-count-based reference model.
module tb_stopwatch_seg_scan;

  localparam int unsigned ND = 4;
  localparam int unsigned SD = 4;
  localparam int unsigned GD = 1;
  localparam int unsigned BF = 2;
  localparam int unsigned FRAME = SD * ND;

  logic CLK = 1'b0;
  logic CLR = 1'b1;

  always #5 CLK = ~CLK;

  stopwatch_seg_scan_if #(.NUM_DIGITS(ND)) bus ();

  stopwatch_seg_scan #(
    .NUM_DIGITS    (ND),
    .SCAN_DIV      (SD),
    .GUARD         (GD),
    .BLINK_FRAMES  (BF),
    .SEG_ACTIVE_LOW(0),
    .AN_ACTIVE_LOW (0)
  ) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state: cycles since CLR release, last captured frame, frames under blink
  int cyc;
  int snap_d [ND];
  int snap_p [ND];
  int frames_on;
  int seg_tab [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                       'h7F, 'h6F, 'h40, 'h40, 'h40, 'h40, 'h40, 'h40};

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    cyc       = 0;
    frames_on = 0;
    for (int k = 0; k < ND; k++) begin
      snap_d[k] = 0;
      snap_p[k] = 0;
    end
  endtask

  // Called at a negedge with inputs settled; advances one clock and checks outputs
  task automatic step();
    int  pre, slot, idx, exp_an, exp_seg, exp_dp, exp_fr;
    bit  allz, blank, eff_on, show;
    pre  = cyc % SD;
    slot = cyc / SD;
    idx  = (cyc < SD) ? ND - 1 : (slot - 1) % ND;
    allz = 1'b1;
    for (int k = idx; k < ND; k++) allz = allz && (snap_d[k] == 0);
    blank  = bus.blank_lz_i && (idx > 0) && allz;
    eff_on = !bus.blink_i || (((frames_on / BF) % 2) == 0);
    show   = (cyc >= SD) && (pre >= GD) && !blank && eff_on;
    exp_an  = show ? (1 << idx) : 0;
    exp_seg = seg_tab[snap_d[idx]];
    exp_dp  = (show && snap_p[idx] != 0) ? 1 : 0;
    exp_fr  = (pre == SD - 1 && (slot % ND) == 0) ? 1 : 0;
    if (exp_fr != 0) begin
      for (int k = 0; k < ND; k++) begin
        snap_d[k] = int'(bus.digits_i[4*k +: 4]);
        snap_p[k] = int'(bus.dp_i[k]);
      end
    end
    if (!bus.blink_i) frames_on = 0;
    else if (exp_fr != 0) frames_on++;
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    check_eq($sformatf("an c=%0d", cyc), int'(bus.an_o), exp_an);
    check_eq($sformatf("seg c=%0d", cyc), int'(bus.seg_o), exp_seg);
    check_eq($sformatf("dp c=%0d", cyc), int'(bus.dp_o), exp_dp);
    check_eq($sformatf("frame c=%0d", cyc), int'(bus.frame_o), exp_fr);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_phase(input int m);
    for (int i = 0; i < 2 * FRAME; i++) begin
      if ((cyc % FRAME) == m) break;
      step();
    end
  endtask

  // Asserted at a negedge; outputs must drop without waiting for a clock edge
  task automatic do_reset();
    CLR = 1'b1;
    #1;
    check_eq("an in reset", int'(bus.an_o), 0);
    check_eq("seg in reset", int'(bus.seg_o), 0);
    check_eq("dp in reset", int'(bus.dp_o), 0);
    check_eq("frame in reset", int'(bus.frame_o), 0);
    @(negedge CLK);
    @(negedge CLK);
    CLR = 1'b0;
    model_reset();
  endtask

  function automatic logic [4*ND-1:0] rand_digits();
    logic [4*ND-1:0] d;
    d = '0;
    for (int k = 0; k < ND; k++) begin
      d[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    end
    return d;
  endfunction

  initial begin
    bus.digits_i   = '0;
    bus.dp_i       = '0;
    bus.blank_lz_i = 1'b0;
    bus.blink_i    = 1'b0;
    model_reset();
    @(negedge CLK);
    do_reset();

    // Basic scan
    bus.digits_i = 16'h1234;
    run(3 * FRAME);

    // Leading zeros
    bus.blank_lz_i = 1'b1;
    bus.digits_i   = 16'h0070;
    run(2 * FRAME);
    bus.digits_i = 16'h0000;
    run(2 * FRAME);
    bus.blank_lz_i = 1'b0;

    // Mid-frame change during the digit-1 slot, then a change on the frame tick cycle
    bus.digits_i = 16'h1234;
    run(2 * FRAME);
    run_to_phase(9);
    bus.digits_i = 16'h5678;
    run(2 * FRAME);
    run_to_phase(SD - 1);
    bus.digits_i = 16'h9012;
    run(2 * FRAME);

    // Invalid code and decimal point
    bus.digits_i = 16'h00A9;
    bus.dp_i     = 4'b0010;
    run(2 * FRAME);

    // Blink, then drop blink_i in the middle of an off phase
    bus.blink_i = 1'b1;
    run(5 * FRAME);
    for (int i = 0; i < 4 * FRAME; i++) begin
      if (((frames_on / BF) % 2) == 1 && (cyc % FRAME) == 6) break;
      step();
    end
    bus.blink_i = 1'b0;
    run(2 * FRAME);

    // Reset during the digit-2 slot
    run_to_phase(13);
    do_reset();
    run(2 * FRAME);

    // Random traffic
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 7) == 0) bus.digits_i = rand_digits();
      if ($urandom_range(0, 7) == 0) bus.dp_i = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) bus.blank_lz_i = ~bus.blank_lz_i;
      if ($urandom_range(0, 63) == 0) bus.blink_i = ~bus.blink_i;
      if ($urandom_range(0, 499) == 0) do_reset();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
